// File: rtl/led_anim_engine_if.sv
// Control/status bundle for led_anim_engine: frame-advance controls in, LED pattern and frame status out.
// LED_ANIM_PWM_EN adds the 4-bit bright input.
interface led_anim_engine_if #(
  parameter int N_LEDS     = 16,
  parameter int PRESCALE_W = 24
);
  localparam int FW = $clog2(2 * N_LEDS);

  logic                  en;
  logic [1:0]            mode;
  logic [PRESCALE_W-1:0] prescale;
`ifdef LED_ANIM_PWM_EN
  logic [3:0]            bright;
`endif
  logic [N_LEDS-1:0]     led;
  logic [FW-1:0]         frame_no;
  logic                  frame_tick;
  logic                  period_done;

`ifdef LED_ANIM_PWM_EN
  modport master (
    output en, mode, prescale, bright,
    input  led, frame_no, frame_tick, period_done
  );
  modport slave (
    input  en, mode, prescale, bright,
    output led, frame_no, frame_tick, period_done
  );
`else
  modport master (
    output en, mode, prescale,
    input  led, frame_no, frame_tick, period_done
  );
  modport slave (
    input  en, mode, prescale,
    output led, frame_no, frame_tick, period_done
  );
`endif
endinterface

// File: rtl/led_anim_engine.sv
// LED bar animation engine: prescaled frame counter over 2*N_LEDS frames, four patterns, registered output.
// Define LED_ANIM_PWM_EN to add a 16-step brightness PWM on the led output.
module led_anim_engine #(
  parameter int N_LEDS     = 16,
  parameter int PRESCALE_W = 24
) (
  input  logic               clk,
  input  logic               rst,
  led_anim_engine_if.slave   bus
);
  localparam int FW = $clog2(2 * N_LEDS);
  localparam logic [FW-1:0] LAST_FRAME = FW'(2 * N_LEDS - 1);

  logic [1:0]            mode_q;
  logic [PRESCALE_W-1:0] pre_cnt;
  logic [FW-1:0]         frame_q;
  logic [N_LEDS-1:0]     led_q;
  logic [N_LEDS-1:0]     pattern;
  logic                  mode_chg;
  logic                  tick;
  logic                  last_frame;

  // A compare of >= lets a prescale lowered mid-count fire on the very next cycle.
  assign mode_chg   = (bus.mode != mode_q);
  assign last_frame = (frame_q == LAST_FRAME);
  assign tick       = !rst && bus.en && !mode_chg && (pre_cnt >= bus.prescale);

  always_comb begin
    int k;
    pattern = '0;
    k       = int'(frame_q);
    case (mode_q)
      2'd0: begin
        for (int i = 0; i < N_LEDS; i++) begin
          pattern[i] = (k <= N_LEDS) ? (i + k >= N_LEDS) : (i + 2 * N_LEDS - k >= N_LEDS);
        end
      end
      2'd1: begin
        for (int i = 0; i < N_LEDS; i++) begin
          pattern[i] = (k < N_LEDS) ? (i == N_LEDS - 1 - k) : (i == k - N_LEDS);
        end
      end
      2'd2: pattern = (k < N_LEDS) ? '1 : '0;
      default: pattern = N_LEDS'(frame_q);
    endcase
  end

`ifdef LED_ANIM_PWM_EN
  logic [3:0] pwm_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  logic [N_LEDS-1:0] led_next;
  assign led_next = pattern & {N_LEDS{pwm_cnt < bus.bright}};
`else
  logic [N_LEDS-1:0] led_next;
  assign led_next = pattern;
`endif

  // Mode change clears the animation ahead of any coincident tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= '0;
      pre_cnt <= '0;
      frame_q <= '0;
      led_q   <= '0;
    end else begin
      mode_q <= bus.mode;
      led_q  <= led_next;
      if (mode_chg) begin
        pre_cnt <= '0;
        frame_q <= '0;
      end else if (tick) begin
        pre_cnt <= '0;
        frame_q <= last_frame ? '0 : frame_q + 1'b1;
      end else if (bus.en) begin
        pre_cnt <= pre_cnt + 1'b1;
      end
    end
  end

  assign bus.led         = led_q;
  assign bus.frame_no    = frame_q;
  assign bus.frame_tick  = tick;
  assign bus.period_done = tick && last_frame;

endmodule

// File: tb/tb_led_anim_engine.sv
// Directed bench for led_anim_engine (N_LEDS=16); the LED_ANIM_PWM_EN build runs the brightness sequence.
module tb_led_anim_engine;
  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  led_anim_engine_if #(.N_LEDS(16), .PRESCALE_W(24)) bus ();
  led_anim_engine #(.N_LEDS(16), .PRESCALE_W(24)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] fill_exp(input int k);
    logic [15:0] ones;
    int m;
    ones = 16'hFFFF;
    m = (k <= 16) ? k : 32 - k;
    return ~(ones >> m);
  endfunction

  function automatic logic [15:0] scan_exp(input int k);
    logic [15:0] one;
    one = 16'h0001;
    return (k < 16) ? (one << (15 - k)) : (one << (k - 16));
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.en = 1'b0;
    bus.mode = 2'd0;
    bus.prescale = '0;
`ifdef LED_ANIM_PWM_EN
    bus.bright = 4'd0;
`endif
    repeat (3) @(negedge clk);
    check("rst_led", bus.led, 0);
    check("rst_frame", bus.frame_no, 0);
    check("rst_tick", bus.frame_tick, 0);
    check("rst_pd", bus.period_done, 0);

`ifndef LED_ANIM_PWM_EN
    begin
      int c;
      int exp_frame;
      int prev_frame;
      int shrink_frame;

      // Fill/bounce, one frame per cycle
      rst = 1'b0;
      bus.en = 1'b1;
      for (int j = 1; j <= 33; j++) begin
        @(negedge clk);
        check("fill_frame", bus.frame_no, j % 32);
        check("fill_led", bus.led, fill_exp((j - 1) % 32));
        check("fill_tick", bus.frame_tick, 1);
        check("fill_pd", bus.period_done, (j % 32) == 31);
        if (j == 17) check("fill_full", bus.led, 16'hFFFF);
        if (j == 32) check("fill_last", bus.led, 16'h8000);
      end

      // Scanner, prescale 3, with en held low 10 cycles mid-count
      bus.mode = 2'd1;
      bus.prescale = 24'd3;
      #1;
      check("chg_no_tick", bus.frame_tick, 0);
      c = 0;
      prev_frame = 0;
      for (int cyc = 0; cyc < 160; cyc++) begin
        @(negedge clk);
        bus.en = !(cyc >= 50 && cyc < 60);
        #1;
        exp_frame = (c / 4) % 32;
        check("scan_frame", bus.frame_no, exp_frame);
        check("scan_tick", bus.frame_tick, bus.en && (c % 4 == 3));
        check("scan_pd", bus.period_done, bus.en && (c % 4 == 3) && exp_frame == 31);
        if (cyc > 0) check("scan_led", bus.led, scan_exp(prev_frame));
        prev_frame = exp_frame;
        if (bus.en) c++;
      end

      // Lowering prescale below the running count ticks at once
      @(negedge clk);
      bus.prescale = 24'd10;
      #1;
      check("big_ps_tick", bus.frame_tick, 0);
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        check("big_ps_wait", bus.frame_tick, 0);
      end
      shrink_frame = 5;
      bus.prescale = 24'd3;
      #1;
      check("shrink_tick", bus.frame_tick, 1);
      check("shrink_frame", bus.frame_no, shrink_frame);
      @(negedge clk);
      check("shrink_adv", bus.frame_no, shrink_frame + 1);
      check("shrink_cnt0", bus.frame_tick, 0);

      // Fill to frame 7 then switch to blink
      bus.mode = 2'd0;
      bus.prescale = '0;
      #1;
      check("chg0_tick", bus.frame_tick, 0);
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (bus.frame_no == 7) break;
      end
      check("reach_f7", bus.frame_no, 7);
      check("f7_led", bus.led, 16'hFC00);
      bus.mode = 2'd2;
      #1;
      check("m2_tick_lost", bus.frame_tick, 0);
      check("m2_pd", bus.period_done, 0);
      @(negedge clk);
      check("m2_frame0", bus.frame_no, 0);
      check("m2_pd_after", bus.period_done, 0);
      check("m2_led_old", bus.led, 16'hFE00);
      @(negedge clk);
      check("m2_led_on", bus.led, 16'hFFFF);
      check("m2_frame1", bus.frame_no, 1);

      // Reset at frame 20 with a tick pending
      bus.prescale = 24'd2;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (bus.frame_no == 20 && bus.frame_tick) break;
      end
      check("reach_f20", bus.frame_no, 20);
      rst = 1'b1;
      bus.mode = 2'd0;
      #1;
      check("rst_abort", bus.frame_tick, 0);
      @(negedge clk);
      check("rst2_led", bus.led, 0);
      check("rst2_frame", bus.frame_no, 0);
      check("rst2_tick", bus.frame_tick, 0);
      check("rst2_pd", bus.period_done, 0);
      rst = 1'b0;
      #1;
      check("rel_c0", bus.frame_tick, 0);
      @(negedge clk);
      check("rel_c1", bus.frame_tick, 0);
      @(negedge clk);
      check("rel_c2", bus.frame_tick, 1);
      check("rel_frame0", bus.frame_no, 0);
      @(negedge clk);
      check("rel_frame1", bus.frame_no, 1);
    end
`else
    begin
      int on_cnt;
      logic [3:0] br_tab [3];
      int exp_tab [3];
      br_tab[0] = 4'd4;  exp_tab[0] = 8;
      br_tab[1] = 4'd0;  exp_tab[1] = 0;
      br_tab[2] = 4'd15; exp_tab[2] = 30;
      rst = 1'b0;
      bus.mode = 2'd2;
      bus.en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("pwm_frame0", bus.frame_no, 0);
      for (int t = 0; t < 3; t++) begin
        bus.bright = br_tab[t];
        @(negedge clk);
        on_cnt = 0;
        for (int i = 0; i < 32; i++) begin
          @(negedge clk);
          if (bus.led == 16'hFFFF) on_cnt++;
          else check("pwm_off_zero", bus.led, 0);
        end
        check("pwm_duty", on_cnt, exp_tab[t]);
      end
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/led_anim_engine.md
LED_ANIM_ENGINE -- requirements
Module: led_anim_engine

Interface
REQ-001 SHALL have parameter N_LEDS, default 16, meaning LED bar width; legal range 2..64.
REQ-002 SHALL have parameter PRESCALE_W, default 24, meaning prescaler compare width.
REQ-003 SHALL define FW = $clog2(2*N_LEDS) as a local width for the frame index.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-006 SHALL have port en, input, 1, which enables frame advance.
REQ-007 SHALL have port mode, input, 2, which selects the animation pattern.
REQ-008 SHALL have port prescale, input, PRESCALE_W, giving the number of extra clocks per frame.
REQ-009 SHALL have port led, output, N_LEDS, the registered LED pattern with the MSB as the leftmost LED.
REQ-010 SHALL have port frame_no, output, FW, the current frame index.
REQ-011 SHALL have port frame_tick, output, 1, a one-cycle pulse on each frame advance.
REQ-012 SHALL have port period_done, output, 1, a one-cycle pulse when the frame index wraps from 2N-1 to 0.

Function
REQ-013 Prescaler SHALL count 0..prescale while en=1, then assert frame_tick for 1 cycle and return to 0.
- prescale=0 gives a tick every enabled cycle.
REQ-014 prescale changed mid-count SHALL take effect at the next compare.
- If the count already exceeds the new value, the counter SHALL tick on the next cycle.
REQ-015 On frame_tick, frame_no SHALL increment modulo 2*N_LEDS.
- period_done SHALL pulse in the same cycle as the tick that wraps 2N-1 to 0.
REQ-016 en=0 SHALL freeze the prescaler and frame_no, and SHALL hold frame_tick and period_done at 0.
REQ-017 led SHALL be registered every cycle from pattern(mode, frame_no), giving 1-cycle latency after frame_no changes.
REQ-018 mode 0 FILL_BOUNCE SHALL light the top k LEDs (MSB-first) for k<=N, and the top 2N-k LEDs for k>N.
REQ-019 mode 1 SCANNER SHALL light a single LED: bit N-1-k for k<N, and bit k-N for k>=N.
REQ-020 mode 2 BLINK SHALL light all LEDs for k<N and no LEDs for k>=N.
REQ-021 mode 3 COUNT SHALL output k in binary, zero-extended (or truncated) to N_LEDS.
REQ-022 A mode change, detected against a registered copy of mode, SHALL clear frame_no and the prescaler in the following cycle without pulsing period_done.
REQ-023 If a mode change and a tick coincide, the mode-change clear SHALL win.

Reset
REQ-024 rst=1 SHALL force led=0, frame_no=0, prescaler=0, frame_tick=0, period_done=0 and registered mode=0 on the next edge.
REQ-025 rst SHALL take priority over en, mode change and tick.
- After reset release, the first tick SHALL occur prescale+1 enabled cycles later.
- Reset asserted mid-animation SHALL abort any pending tick.

Configuration
REQ-026 Macro LED_ANIM_PWM_EN defined SHALL add input port bright, 4 bits, and a free-running 4-bit PWM counter that resets to 0.
- led SHALL equal the pattern ANDed with {N_LEDS{pwm_cnt < bright}}.
- bright=0 SHALL be fully off; bright=15 SHALL give a 15/16 duty cycle.
REQ-027 Without LED_ANIM_PWM_EN, the bright port and PWM counter SHALL be absent, and led SHALL equal the pattern directly.

Verification
REQ-028 N=16, mode 0, prescale=0, en=1 -> led sequence 0x0000, 0x8000, 0xC000 ... 0xFFFF (frame 16) ... 0x8000 (frame 31); period_done pulses on the wrap to frame 0.
REQ-029 mode 1, prescale=3 -> frame_tick every 4 cycles; led 0x8000, 0x4000 ... 0x0001, 0x0001, 0x0002 ... 0x8000.
REQ-030 en toggled low for 10 cycles mid-count -> frame_no and the prescaler hold, and resume from the exact same count.
REQ-031 Mode switched 0->2 at frame 7 -> frame_no=0 next cycle, led=0xFFFF one cycle later, and no period_done pulse.
REQ-032 rst asserted at frame 20 with a tick pending -> all outputs 0 next cycle; the first tick comes prescale+1 cycles after release.
REQ-033 LED_ANIM_PWM_EN defined, mode 2 frame 0, bright=4 -> led=0xFFFF for exactly 4 of every 16 cycles; bright=0 -> led stays 0.
